fetch_decode_queue: RTL and testbench

//  Instruction queue between the fetch stage and decode. Buffers each fetched instruction

---
 rtl/fetch_decode_queue.sv | 109 ++++++++++
 tb/tb_fetch_decode_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue holding {instr, PC+2} pairs, flushed on redirect.
// Optional same-cycle empty-queue bypass enabled by defining FDQ_BYPASS_EN.
module fetch_decode_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [15:0]              in_instr,
  input  logic [15:0]              in_pc2,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [15:0]              out_instr,
  output logic [15:0]              out_pc2,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          err_q,    err_d;

  logic   bypass;
  logic   push, pop;
  logic   bypass_take;
  logic   store, deq;
  entry_t head;

  assign head     = mem_q[rd_ptr_q];
  assign in_ready = (count_q != FULL);
  assign count    = count_q;
  assign err      = err_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    bypass    = 1'b0;
    out_valid = 1'b0;
    out_instr = NOP_INSTR;
    out_pc2   = 16'h0000;
`ifdef FDQ_BYPASS_EN
    bypass = (count_q == '0) && in_valid && !flush;
`endif
    if (bypass) begin
      out_valid = 1'b1;
      out_instr = in_instr;
      out_pc2   = in_pc2;
    end else if (count_q != '0) begin
      out_valid = 1'b1;
      out_instr = head.instr;
      out_pc2   = head.pc2;
    end
  end

  always_comb begin
    push        = in_valid && in_ready && !flush;
    pop         = out_valid && out_ready && !flush;
    // A bypassed instruction consumed the same cycle never touches storage.
    bypass_take = bypass && out_ready;
    store       = push && !bypass_take;
    deq         = pop && !bypass_take;

    wr_ptr_d = wr_ptr_q + AW'(store);
    rd_ptr_d = rd_ptr_q + AW'(deq);
    count_d  = count_q + CW'(store) - CW'(deq);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    err_d = err_q || (in_valid && !in_ready && !flush);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= '{instr: in_instr, pc2: in_pc2};
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: stimulus queues expected {instr,pc2}, a monitor checks pops.
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [15:0] in_pc2;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc2;
  logic        out_ready;
  logic [2:0]  count;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fetch_decode_queue #(.DEPTH(4), .NOP_INSTR(16'h0800)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc2    (in_pc2),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc2   (out_pc2),
    .out_ready (out_ready),
    .count     (count),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] instr, input logic [15:0] pc2);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc2   = pc2;
    exp_q.push_back({instr, pc2});
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 32 && exp_q.size() != 0; i++) step();
    check(name, exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  // Monitor: compares every accepted head against the scoreboard; idle head must read NOP.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", {out_instr, out_pc2}, 32'h0);
        end else begin
          check("pop_data", {out_instr, out_pc2}, exp_q.pop_front());
        end
      end else if (!out_valid) begin
        check("idle_nop", {out_instr, out_pc2}, {16'h0800, 16'h0000});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc2 = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 16'h0800);
    check("rst_out_pc2", out_pc2, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_err", err, 0);
    rst = 1'b1;

    // Fill to full, then drain in order
    for (int i = 0; i < 4; i++) push_one(16'h4001 + 16'(i), 16'(2 * (i + 1)));
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    drain("drain_fill");
    check("after_drain_instr", out_instr, 16'h0800);
    check("after_drain_valid", out_valid, 0);

    // Overflow attempt sets sticky err; FFFF must never appear
    for (int i = 0; i < 4; i++) push_one(16'h4101 + 16'(i), 16'h0100 + 16'(i));
    in_valid = 1'b1; in_instr = 16'hFFFF; in_pc2 = 16'hFFFE;
    step();
    in_valid = 1'b0;
    check("ovf_err", err, 1);
    check("ovf_count", count, 4);
    step();
    check("ovf_err_sticky", err, 1);
    drain("drain_ovf");
    check("ovf_err_after_drain", err, 1);

    // Steady push+pop at count=2 for 10 cycles; pointers wrap
    push_one(16'h5000, 16'h0500);
    push_one(16'h5001, 16'h0502);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_instr = 16'h5002 + 16'(i);
      in_pc2   = 16'h0504 + 16'(2 * i);
      exp_q.push_back({in_instr, in_pc2});
      step();
      check("steady_count", count, 2);
    end
    in_valid = 1'b0;
    drain("drain_steady");

    // Flush with a concurrent push at count=3
    for (int i = 0; i < 3; i++) push_one(16'h6000 + 16'(i), 16'h0600 + 16'(i));
    check("pre_flush_count", count, 3);
    in_valid = 1'b1; in_instr = 16'hA5A5; in_pc2 = 16'h5A5A; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_instr", out_instr, 16'h0800);
    check("flush_keeps_err", err, 1);
    out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;

    // Empty-queue push with decode ready
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 16'hC123; in_pc2 = 16'h0042;
    exp_q.push_back({16'hC123, 16'h0042});
    @(negedge clk);
`ifdef FDQ_BYPASS_EN
    check("bypass_valid", out_valid, 1);
    check("bypass_instr", out_instr, 16'hC123);
`else
    check("nobypass_valid", out_valid, 0);
`endif
    step();
    in_valid = 1'b0;
`ifdef FDQ_BYPASS_EN
    check("bypass_count", count, 0);
`else
    check("nobypass_count", count, 1);
    check("nobypass_instr", out_instr, 16'hC123);
`endif
    drain("drain_c123");

    // Reset mid-operation at count=3, with live traffic on the inputs
    for (int i = 0; i < 3; i++) push_one(16'h7000 + 16'(i), 16'h0700 + 16'(i));
    check("pre_rst_count", count, 3);
    rst = 1'b0; in_valid = 1'b1; in_instr = 16'h7777; out_ready = 1'b1;
    step();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    check("midrst_count", count, 0);
    check("midrst_err", err, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
